// File: rtl/rx_error_counter.sv
// rx_error_counter: symbol-error counter behind the 4-channel hard-decision slicer.
//   Each accepted beat carries four decided symbols (16'h0001 = +1, 16'h8000 = -1) and
//   four reference bits (1 = -1 sent). Errors are counted over FRAME_LEN beats with
//   saturating counters. The end of the frame is flagged with a one-cycle done pulse.
//
// Optional feature (macro RX_PER_CHAN_CNT_EN):
//   defined   -> err_ch1..4 hold per-channel saturating error counts.
//   undefined -> err_ch1..4 are tied to 0 and no per-channel registers are built.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   start                pulse: begin a new frame and clear the counters
//   in_valid / in_ready  beat handshake (in_ready is high only while running)
//   rx_sym1..rx_sym4     decided symbols, channels 1..4
//   ref_bits[3:0]        transmitted bits; bit k-1 belongs to channel k
//   busy                 frame in progress
//   done                 one-cycle pulse after the final beat of a frame
//   err_count            total symbol errors in the current or last frame
//   illegal_seen         sticky: a non-legal symbol code was accepted this frame
//   err_ch1..err_ch4     per-channel error counts (0 when the feature is disabled)
module rx_error_counter #(
  parameter int unsigned FRAME_LEN = 256,
  parameter int unsigned ERR_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      rx_sym1,
  input  logic [15:0]      rx_sym2,
  input  logic [15:0]      rx_sym3,
  input  logic [15:0]      rx_sym4,
  input  logic [3:0]       ref_bits,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_count,
  output logic             illegal_seen,
  output logic [ERR_W-1:0] err_ch1,
  output logic [ERR_W-1:0] err_ch2,
  output logic [ERR_W-1:0] err_ch3,
  output logic [ERR_W-1:0] err_ch4
);

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned BEAT_W = 16;
  // Sum width wide enough for a full 4-error beat even with very narrow counters.
  localparam int unsigned SUM_W  = ((ERR_W > 3) ? ERR_W : 3) + 1;

  localparam logic [15:0]       SYM_POS   = 16'h0001;
  localparam logic [15:0]       SYM_NEG   = 16'h8000;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
  localparam logic [SUM_W-1:0]  CNT_MAX   = SUM_W'({ERR_W{1'b1}});

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Saturating add of a 0..4 increment onto an ERR_W counter.
  function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                               input logic [2:0]       b);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
    if (sum > CNT_MAX) begin
      return {ERR_W{1'b1}};
    end
    return ERR_W'(sum);
  endfunction

  state_e state_q;
  logic   in_ready_q;
  logic   busy_q;
  logic   done_q;

  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic              illegal_q,   illegal_d;
  logic [BEAT_W-1:0] beat_cnt_q,  beat_cnt_d;

  logic [15:0]       sym_c      [NUM_CH];
  logic [NUM_CH-1:0] sym_legal_c;
  logic [NUM_CH-1:0] sym_err_c;
  logic [2:0]        beat_errs_c;

  logic accept_c;
  logic clr_c;
  logic upd_c;
  logic last_c;

  // Per-symbol decision: sign bit versus reference, plus illegal-code detection.
  always_comb begin
    sym_c[0] = rx_sym1;
    sym_c[1] = rx_sym2;
    sym_c[2] = rx_sym3;
    sym_c[3] = rx_sym4;
    sym_legal_c = '0;
    sym_err_c   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sym_legal_c[k] = (sym_c[k] == SYM_POS) || (sym_c[k] == SYM_NEG);
      sym_err_c[k]   = (sym_c[k][15] != ref_bits[k]) || !sym_legal_c[k];
    end
    beat_errs_c = 3'(sym_err_c[0]) + 3'(sym_err_c[1])
                + 3'(sym_err_c[2]) + 3'(sym_err_c[3]);
  end

  // in_ready is high exactly in RUN, so accept implies RUN.
  // start in IDLE or RUN clears; a beat coinciding with start is dropped.
  always_comb begin
    accept_c = in_valid && in_ready_q;
    clr_c    = start && (state_q != ST_DONE);
    upd_c    = accept_c && !start;
    last_c   = upd_c && (beat_cnt_q == LAST_BEAT);
  end

  // Next-state of the frame counters.
  always_comb begin
    err_count_d = err_count_q;
    illegal_d   = illegal_q;
    beat_cnt_d  = beat_cnt_q;
    if (clr_c) begin
      err_count_d = '0;
      illegal_d   = 1'b0;
      beat_cnt_d  = '0;
    end else if (upd_c) begin
      err_count_d = sat_add(err_count_q, beat_errs_c);
      illegal_d   = illegal_q || !(&sym_legal_c);
      beat_cnt_d  = last_c ? '0 : beat_cnt_q + BEAT_W'(1);
    end
  end

  // Frame-control FSM with registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q    <= ST_RUN;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (last_c) begin
            state_q    <= ST_DONE;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // Frame counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count_q <= '0;
      illegal_q   <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      err_count_q <= err_count_d;
      illegal_q   <= illegal_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_count    = err_count_q;
  assign illegal_seen = illegal_q;

`ifdef RX_PER_CHAN_CNT_EN
  logic [ERR_W-1:0] err_ch_q [NUM_CH];
  logic [ERR_W-1:0] err_ch_d [NUM_CH];

  // Per-channel counters share the clear/update timing of err_count.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      err_ch_d[k] = err_ch_q[k];
      if (clr_c) begin
        err_ch_d[k] = '0;
      end else if (upd_c) begin
        err_ch_d[k] = sat_add(err_ch_q[k], 3'(sym_err_c[k]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        err_ch_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        err_ch_q[k] <= err_ch_d[k];
      end
    end
  end

  assign err_ch1 = err_ch_q[0];
  assign err_ch2 = err_ch_q[1];
  assign err_ch3 = err_ch_q[2];
  assign err_ch4 = err_ch_q[3];
`else
  assign err_ch1 = '0;
  assign err_ch2 = '0;
  assign err_ch3 = '0;
  assign err_ch4 = '0;
`endif

endmodule

// File: tb/tb_rx_error_counter.sv
// Self-checking bench for rx_error_counter: directed scenarios plus randomized frames
// checked against a symbol-level reference model.
module tb_rx_error_counter;

  logic clk = 1'b0;
  logic rst_n, start, in_valid, start_s, in_valid_s;
  logic [15:0] rx_sym1, rx_sym2, rx_sym3, rx_sym4;
  logic [3:0]  ref_bits;

  logic        in_ready, busy, done, illegal_seen;
  logic [15:0] err_count, err_ch1, err_ch2, err_ch3, err_ch4;

  logic        in_ready_s, busy_s, done_s, illegal_s;
  logic [1:0]  err_count_s, err_ch1_s, err_ch2_s, err_ch3_s, err_ch4_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rx_error_counter #(.FRAME_LEN(4), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .rx_sym1(rx_sym1), .rx_sym2(rx_sym2), .rx_sym3(rx_sym3), .rx_sym4(rx_sym4),
    .ref_bits(ref_bits), .busy(busy), .done(done), .err_count(err_count),
    .illegal_seen(illegal_seen), .err_ch1(err_ch1), .err_ch2(err_ch2),
    .err_ch3(err_ch3), .err_ch4(err_ch4)
  );

  rx_error_counter #(.FRAME_LEN(2), .ERR_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
    .rx_sym1(rx_sym1), .rx_sym2(rx_sym2), .rx_sym3(rx_sym3), .rx_sym4(rx_sym4),
    .ref_bits(ref_bits), .busy(busy_s), .done(done_s), .err_count(err_count_s),
    .illegal_seen(illegal_s), .err_ch1(err_ch1_s), .err_ch2(err_ch2_s),
    .err_ch3(err_ch3_s), .err_ch4(err_ch4_s)
  );

  // ---------------- reference model ----------------
  // A symbol is correct only if it is exactly the code for the transmitted value.
  function automatic int sym_err(input logic [15:0] s, input logic r);
    if (s == 16'h0001) return (r == 1'b0) ? 0 : 1;
    if (s == 16'h8000) return (r == 1'b1) ? 0 : 1;
    return 1;
  endfunction

  function automatic int sym_illegal(input logic [15:0] s);
    return (s != 16'h0001 && s != 16'h8000) ? 1 : 0;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  function automatic logic [15:0] rand_sym();
    int r;
    r = $urandom_range(0, 7);
    if (r < 3) return 16'h0001;
    if (r < 6) return 16'h8000;
    if (r == 6) return 16'($urandom);
    return 16'h0000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] s1, input logic [15:0] s2, input logic [15:0] s3,
                       input logic [15:0] s4, input logic [3:0] rb, input logic v);
    rx_sym1 = s1; rx_sym2 = s2; rx_sym3 = s3; rx_sym4 = s4;
    ref_bits = rb; in_valid = v;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; start_s = 1'b0; in_valid_s = 1'b0;
    drive(16'h0, 16'h0, 16'h0, 16'h0, 4'h0, 1'b0);
    step(); step();
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({in_ready, busy, done, illegal_seen} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000", {in_ready, busy, done, illegal_seen});
    end
    n_checks++;
    if (err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_err_count: got %0d expected 0", err_count);
    end
  endtask

  task automatic test_clean();
    pulse_start();
    n_checks++;
    if ({in_ready, busy, done} !== 3'b110) begin
      n_fail++;
      $display("FAIL clean_run_flags: got %b expected 110", {in_ready, busy, done});
    end
    for (int i = 0; i < 4; i++) begin
      drive(16'h0001, 16'h8000, 16'h0001, 16'h8000, 4'b1010, 1'b1);
      step();
      n_checks++;
      if (done !== (i == 3)) begin
        n_fail++;
        $display("FAIL clean_done_beat%0d: got %b expected %b", i, done, (i == 3));
      end
    end
    n_checks++;
    if (err_count !== 16'd0 || illegal_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_result: got err=%0d ill=%b expected err=0 ill=0", err_count, illegal_seen);
    end
    n_checks++;
    if ({in_ready, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL clean_done_flags: got %b expected 00", {in_ready, busy});
    end
    in_valid = 1'b0;
    step();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_done_width: got %b expected 0", done);
    end
  endtask

  task automatic test_errors();
    int exp;
    exp = 0;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      drive(16'h8000, 16'h8000, 16'h0001, 16'h0001, 4'b0000, 1'b1);
      exp = sat(exp + sym_err(16'h8000, 1'b0) + sym_err(16'h8000, 1'b0)
                    + sym_err(16'h0001, 1'b0) + sym_err(16'h0001, 1'b0), 65535);
      step();
      n_checks++;
      if (err_count !== 16'(exp)) begin
        n_fail++;
        $display("FAIL errors_count_beat%0d: got %0d expected %0d", i, err_count, exp);
      end
    end
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL errors_done: got %b expected 1", done);
    end
`ifdef RX_PER_CHAN_CNT_EN
    n_checks++;
    if ({err_ch1, err_ch2, err_ch3, err_ch4} !== {16'd4, 16'd4, 16'd0, 16'd0}) begin
      n_fail++;
      $display("FAIL errors_per_chan: got %0d %0d %0d %0d expected 4 4 0 0",
               err_ch1, err_ch2, err_ch3, err_ch4);
    end
`else
    n_checks++;
    if ({err_ch1, err_ch2, err_ch3, err_ch4} !== 64'd0) begin
      n_fail++;
      $display("FAIL errors_per_chan_tied: got %0d %0d %0d %0d expected 0 0 0 0",
               err_ch1, err_ch2, err_ch3, err_ch4);
    end
`endif
    // Beats offered while idle must not be counted.
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (err_count !== 16'(exp) || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_ignore_%0d: got err=%0d busy=%b done=%b expected err=%0d busy=0 done=0",
                 i, err_count, busy, done, exp);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_illegal();
    pulse_start();
    drive(16'h0001, 16'h8000, 16'h1234, 16'h8000, 4'b1010, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(16'h0001, 16'h8000, 16'h0001, 16'h8000, 4'b1010, 1'b1);
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (done !== 1'b1 || err_count !== 16'd1 || illegal_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_result: got done=%b err=%0d ill=%b expected done=1 err=1 ill=1",
               done, err_count, illegal_seen);
    end
    step(); step(); step();
    n_checks++;
    if (err_count !== 16'd1 || illegal_seen !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_hold: got err=%0d ill=%b expected err=1 ill=1", err_count, illegal_seen);
    end
    pulse_start();
    n_checks++;
    if (err_count !== 16'd0 || illegal_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_clear: got err=%0d ill=%b expected err=0 ill=0", err_count, illegal_seen);
    end
    for (int i = 0; i < 4; i++) begin
      drive(16'h0001, 16'h8000, 16'h0001, 16'h8000, 4'b1010, 1'b1);
      step();
    end
    in_valid = 1'b0;
    step(); step();
  endtask

  task automatic test_saturation();
    int exp;
    exp = 0;
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    drive(16'h0001, 16'h0001, 16'h0001, 16'h0001, 4'b1111, 1'b0);
    in_valid_s = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp = sat(exp + 4 * sym_err(16'h0001, 1'b1), 3);
      step();
      n_checks++;
      if (err_count_s !== 2'(exp)) begin
        n_fail++;
        $display("FAIL sat_count_beat%0d: got %0d expected %0d", i, err_count_s, exp);
      end
    end
    n_checks++;
    if (done_s !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_done: got %b expected 1", done_s);
    end
    in_valid_s = 1'b0;
    step();
  endtask

  task automatic test_restart();
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      drive(16'h8000, 16'h8000, 16'h0001, 16'h0001, 4'b0000, 1'b1);
      step();
    end
    n_checks++;
    if (err_count !== 16'd4) begin
      n_fail++;
      $display("FAIL restart_pre: got %0d expected 4", err_count);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++;
    if (err_count !== 16'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL restart_clear: got err=%0d busy=%b expected err=0 busy=1", err_count, busy);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (done !== (i == 3)) begin
        n_fail++;
        $display("FAIL restart_done_beat%0d: got %b expected %b", i, done, (i == 3));
      end
    end
    n_checks++;
    if (err_count !== 16'd8) begin
      n_fail++;
      $display("FAIL restart_final: got %0d expected 8", err_count);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_midframe();
    int dones;
    dones = 0;
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      drive(16'h8000, 16'h8000, 16'h0001, 16'h0001, 4'b0000, 1'b1);
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if ({in_ready, busy, done} !== 3'b000 || err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL midreset_state: got flags=%b err=%0d expected flags=000 err=0",
               {in_ready, busy, done}, err_count);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      if (done === 1'b1 || err_count !== 16'd0) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL midreset_quiet: got %0d bad cycles expected 0", dones);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [15:0] s [4];
    logic [3:0]  rb;
    logic        v;
    int exp, exp_ill, beats, cyc;
    int exp_ch [4];
    for (int f = 0; f < 20; f++) begin
      exp = 0; exp_ill = 0; beats = 0; cyc = 0;
      for (int k = 0; k < 4; k++) exp_ch[k] = 0;
      pulse_start();
      while (beats < 4 && cyc < 200) begin
        for (int k = 0; k < 4; k++) s[k] = rand_sym();
        rb = 4'($urandom);
        v  = 1'($urandom);
        drive(s[0], s[1], s[2], s[3], rb, v);
        step();
        cyc++;
        if (v) begin
          for (int k = 0; k < 4; k++) begin
            exp       = sat(exp + sym_err(s[k], rb[k]), 65535);
            exp_ch[k] = sat(exp_ch[k] + sym_err(s[k], rb[k]), 65535);
            if (sym_illegal(s[k]) != 0) exp_ill = 1;
          end
          beats++;
        end
        n_checks++;
        if (err_count !== 16'(exp) || done !== (v && beats == 4)) begin
          n_fail++;
          $display("FAIL random_f%0d_c%0d: got err=%0d done=%b expected err=%0d done=%b",
                   f, cyc, err_count, done, exp, (v && beats == 4));
        end
`ifdef RX_PER_CHAN_CNT_EN
        n_checks++;
        if ({err_ch1, err_ch2, err_ch3, err_ch4} !==
            {16'(exp_ch[0]), 16'(exp_ch[1]), 16'(exp_ch[2]), 16'(exp_ch[3])}) begin
          n_fail++;
          $display("FAIL random_ch_f%0d_c%0d: got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                   f, cyc, err_ch1, err_ch2, err_ch3, err_ch4,
                   exp_ch[0], exp_ch[1], exp_ch[2], exp_ch[3]);
        end
`endif
      end
      if (beats < 4) begin
        n_checks++;
        n_fail++;
        $display("FAIL random_timeout_f%0d: got %0d beats expected 4", f, beats);
      end
      n_checks++;
      if (illegal_seen !== 1'(exp_ill)) begin
        n_fail++;
        $display("FAIL random_illegal_f%0d: got %b expected %0d", f, illegal_seen, exp_ill);
      end
      in_valid = 1'b0;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean();
    test_errors();
    test_illegal();
    test_saturation();
    test_restart();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_error_counter.md
Name: rx_error_counter

Overview:
- Downstream of the 4-channel hard-decision slicer. Consumes its decided symbols: 16'h0001 = +1, 16'h8000 = -1.
- Compares each symbol against the transmitted reference bits and accumulates symbol-error counts over a fixed-length frame.
- Reports the frame result with a done pulse, for BER measurement of the noise-filter chain.

Parameters:
- FRAME_LEN, 256, accepted beats per frame (each beat carries 4 symbols); legal range 1..65535.
- ERR_W, 16, width of the error counters; counters saturate at all-ones.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  pulse; begins a new frame and clears the counters.
- in_valid  input  1  rx_sym1..4 and ref_bits are valid this cycle.
- in_ready  output  1  block accepts a beat this cycle.
- rx_sym1  input  16  decided symbol, channel 1.
- rx_sym2  input  16  decided symbol, channel 2.
- rx_sym3  input  16  decided symbol, channel 3.
- rx_sym4  input  16  decided symbol, channel 4.
- ref_bits  input  4  transmitted bits; bit k-1 belongs to channel k; 1 means -1 was sent.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at frame end.
- err_count  output  ERR_W  total symbol errors in the current or last frame.
- illegal_seen  output  1  sticky; a symbol other than 16'h0001 or 16'h8000 was accepted this frame.
- err_ch1..err_ch4  output  ERR_W each  per-channel error counts (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state goes to IDLE.
  - in_ready, busy, done, illegal_seen are 0.
  - err_count, all err_chN and the beat counter are 0.
  - Reset mid-frame abandons the frame; no done pulse is produced.
- States and transitions:
  - IDLE -> RUN on start. The same edge clears err_count, err_chN, illegal_seen and the beat counter.
  - RUN: in_ready=1, busy=1. A beat is accepted when in_valid && in_ready.
  - RUN -> DONE on the accept where the beat counter equals FRAME_LEN-1.
  - RUN with start (with or without a same-cycle accept): restart. Counters are cleared, the same-cycle beat is discarded, state stays RUN.
  - DONE: lasts one cycle. done=1, in_ready=0, busy=0. Then DONE -> IDLE.
  - start during DONE is ignored.
  - IDLE: in_ready=0. Results hold until the next start.
- Per-symbol decision, channel k:
  - decoded bit = rx_symk[15].
  - The symbol is an error if decoded bit != ref_bits[k-1].
  - The symbol is also an error if rx_symk is neither 16'h0001 nor 16'h8000; this also sets illegal_seen.
- Per accepted beat:
  - The beat's error count is 0..4 (popcount of the 4 error flags).
  - err_count <= min(err_count + count, 2^ERR_W - 1). Saturating; no wrap.
- Latency:
  - Counters update on the edge that accepts the beat and are visible the following cycle.
  - done is high in the cycle after the final accept, with err_count already including the final beat.
- in_valid while not in RUN is ignored. There is no back-pressure inside RUN.

Optional Feature:
- Macro: RX_PER_CHAN_CNT_EN.
- Defined:
  - err_ch1..4 each count errors on their own channel.
  - Same clear, saturation and latency rules as err_count.
  - err_count always equals the saturating sum of the channel increments.
- Undefined:
  - err_ch1..4 ports remain and are tied to constant 0; no per-channel registers are built.
  - err_count behaviour is unchanged.

Test Plan (FRAME_LEN=4, ERR_W=16 unless noted):
- Clean frame: start, then 4 beats with syms {0001,8000,0001,8000} and ref_bits=4'b1010 -> done one cycle after beat 4, err_count=0, illegal_seen=0.
- Errors: beats with ref_bits=4'b0000 and syms {8000,8000,0001,0001} x4 -> err_count=8. With the macro defined: err_ch1=4, err_ch2=4, err_ch3=0, err_ch4=0.
- Illegal code: a single beat with rx_sym3=16'h1234 and the rest matching -> err_count=1, illegal_seen=1, held after done until the next start.
- Saturation (ERR_W=2, FRAME_LEN=2): two beats with all 4 symbols wrong -> err_count=3, not wrapped.
- Restart: start asserted after 2 accepted beats containing errors, with in_valid=1 on that cycle -> counters become 0; done arrives only after 4 further beats.
- Reset: rst_n=0 for one edge mid-frame -> in the next cycle state is IDLE, err_count=0, busy=0, and no done pulse follows. in_valid in IDLE leaves err_count unchanged.
